ppu_palette_writer: RTL and testbench

//  CPU-side initiator for the PPU palette memory port. Decodes PPUADDR ($2006) and PPUDATA ($2007)

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/ppu_pal_wr_fifo.sv | 46 ++++
 rtl/ppu_palette_writer.sv | 134 +++++++++++++
 tb/tb_ppu_palette_writer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side palette write path: register indices,
// the palette page, the queued write entry and the palette index mirroring rule.
package ppu_pkg;

  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  localparam logic [5:0] PAL_PAGE  = 6'h3F;

  typedef struct packed {
    logic [4:0] idx;
    logic [5:0] col;
  } pal_wr_t;

  // Sprite backdrop slots 0x10/14/18/1C alias the background slots 0x00/04/08/0C.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

// File: rtl/ppu_pal_wr_fifo.sv
// Small synchronous FIFO of queued palette writes; a push into a full queue is
// accepted when a pop happens in the same cycle.
module ppu_pal_wr_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  pal_wr_t din_i,
  input  logic    pop_i,
  output pal_wr_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  pal_wr_t       mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          rd_en, wr_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ppu_palette_writer.sv
// CPU-side palette port initiator: PPUADDR/PPUDATA decode, VRAM address and write
// toggle, palette-write queue, and the registered renderer-first palette port mux.
module ppu_palette_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_reg_sel,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        incr32,
  input  logic        render_pal_req,
  input  logic [4:0]  render_pal_addr,
  output logic [4:0]  pal_addr,
  output logic [7:0]  palette_data_in,
  output logic        palette_mem_rw,
  output logic        palette_mem_en,
  output logic [13:0] vram_addr,
  output logic        vram_wr,
  output logic [7:0]  vram_wr_data,
  output logic        fifo_full,
  output logic        wr_dropped
);

  logic [13:0] vram_addr_q, vram_addr_d;
  logic        w_q, w_d;
  logic        vram_wr_q, vram_wr_d;
  logic [7:0]  vram_wr_data_q, vram_wr_data_d;
  logic        dropped_q, dropped_d;
  logic [4:0]  pal_addr_q;
  logic [7:0]  pal_data_q;
  logic        pal_en_q, pal_rw_q;

  logic        wr_addr, wr_data, rd_status;
  logic        push, pop, fifo_empty;
  pal_wr_t     push_entry, head;

  assign wr_addr   = cpu_we && (cpu_reg_sel == PPUADDR);
  assign wr_data   = cpu_we && (cpu_reg_sel == PPUDATA);
  assign rd_status = cpu_re && (cpu_reg_sel == PPUSTATUS);

  assign pop = !render_pal_req && !fifo_empty;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    vram_addr_d    = vram_addr_q;
    w_d            = w_q;
    vram_wr_d      = 1'b0;
    vram_wr_data_d = vram_wr_data_q;
    push           = 1'b0;
    push_entry     = '{idx: pal_mirror(vram_addr_q[4:0]), col: cpu_data_in[5:0]};

    if (wr_addr) begin
      if (!w_q) vram_addr_d[13:8] = cpu_data_in[5:0];
      else      vram_addr_d[7:0]  = cpu_data_in;
      w_d = !w_q;
    end

    if (wr_data) begin
      if (vram_addr_q[13:8] == PAL_PAGE) begin
        push = 1'b1;
      end else begin
        vram_wr_d      = 1'b1;
        vram_wr_data_d = cpu_data_in;
      end
      vram_addr_d = vram_addr_q + (incr32 ? 14'd32 : 14'd1);
    end

    // A status read lands after any same-cycle address write, so it wins on the toggle.
    if (rd_status) w_d = 1'b0;

    dropped_d = push && fifo_full && !pop;
  end

  ppu_pal_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr_q    <= '0;
      w_q            <= 1'b0;
      vram_wr_q      <= 1'b0;
      vram_wr_data_q <= '0;
      dropped_q      <= 1'b0;
      pal_addr_q     <= '0;
      pal_data_q     <= '0;
      pal_en_q       <= 1'b0;
      pal_rw_q       <= 1'b0;
    end else begin
      vram_addr_q    <= vram_addr_d;
      w_q            <= w_d;
      vram_wr_q      <= vram_wr_d;
      vram_wr_data_q <= vram_wr_data_d;
      dropped_q      <= dropped_d;

      if (render_pal_req) begin
        pal_en_q   <= 1'b1;
        pal_rw_q   <= 1'b0;
        pal_addr_q <= render_pal_addr;
        pal_data_q <= '0;
      end else if (!fifo_empty) begin
        pal_en_q   <= 1'b1;
        pal_rw_q   <= 1'b1;
        pal_addr_q <= head.idx;
        pal_data_q <= {2'b00, head.col};
      end else begin
        pal_en_q   <= 1'b0;
        pal_rw_q   <= 1'b0;
      end
    end
  end

  assign vram_addr       = vram_addr_q;
  assign vram_wr         = vram_wr_q;
  assign vram_wr_data    = vram_wr_data_q;
  assign wr_dropped      = dropped_q;
  assign pal_addr        = pal_addr_q;
  assign palette_data_in = pal_data_q;
  assign palette_mem_en  = pal_en_q;
  assign palette_mem_rw  = pal_rw_q;

endmodule

// File: tb/tb_ppu_palette_writer.sv
// Scoreboard bench for ppu_palette_writer: expected palette and VRAM writes are queued
// as the CPU drives registers and compared when they appear on the outputs.
module tb_ppu_palette_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cpu_reg_sel;
  logic [7:0]  cpu_data_in;
  logic        cpu_we, cpu_re, incr32;
  logic        render_pal_req;
  logic [4:0]  render_pal_addr;
  logic [4:0]  pal_addr;
  logic [7:0]  palette_data_in;
  logic        palette_mem_rw, palette_mem_en;
  logic [13:0] vram_addr;
  logic        vram_wr;
  logic [7:0]  vram_wr_data;
  logic        fifo_full, wr_dropped;

  always #5 clk = ~clk;

  ppu_palette_writer #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_reg_sel     (cpu_reg_sel),
    .cpu_data_in     (cpu_data_in),
    .cpu_we          (cpu_we),
    .cpu_re          (cpu_re),
    .incr32          (incr32),
    .render_pal_req  (render_pal_req),
    .render_pal_addr (render_pal_addr),
    .pal_addr        (pal_addr),
    .palette_data_in (palette_data_in),
    .palette_mem_rw  (palette_mem_rw),
    .palette_mem_en  (palette_mem_en),
    .vram_addr       (vram_addr),
    .vram_wr         (vram_wr),
    .vram_wr_data    (vram_wr_data),
    .fifo_full       (fifo_full),
    .wr_dropped      (wr_dropped)
  );

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } pal_exp_t;

  pal_exp_t   sb_q[$];
  logic [7:0] vq[$];
  pal_exp_t   e_pal;
  logic [7:0] e_vram;
  int         checks   = 0;
  int         failures = 0;
  int         drop_cnt = 0;
  int         drop_base;

  logic [13:0] m_v;
  logic        m_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] mirror(input logic [4:0] a);
    if (a[1:0] == 2'b00) return a & 5'h0F;
    return a;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the strobe edge.
  task automatic cpu_write(input logic [2:0] sel, input logic [7:0] data, input bit drop = 0);
    pal_exp_t p;
    cpu_we = 1'b1; cpu_reg_sel = sel; cpu_data_in = data;
    if (sel == 3'd6) begin
      if (!m_w) m_v[13:8] = data[5:0];
      else      m_v[7:0]  = data;
      m_w = !m_w;
    end else if (sel == 3'd7) begin
      if (m_v[13:8] == 6'h3F) begin
        if (!drop) begin
          p.a = mirror(m_v[4:0]);
          p.d = {2'b00, data[5:0]};
          sb_q.push_back(p);
        end
      end else begin
        vq.push_back(data);
      end
      m_v = m_v + (incr32 ? 14'd32 : 14'd1);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] sel);
    cpu_re = 1'b1; cpu_reg_sel = sel;
    if (sel == 3'd2) m_w = 1'b0;
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (sb_q.size() != 0 || vq.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_pal", sb_q.size(), 0);
    check("drain_vram", vq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (palette_mem_en && palette_mem_rw) begin
        check("pal_wr_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e_pal = sb_q.pop_front();
          check("pal_addr", pal_addr, e_pal.a);
          check("pal_data", palette_data_in, e_pal.d);
        end
      end
      if (vram_wr) begin
        check("vram_wr_expected", vq.size() != 0, 1);
        if (vq.size() != 0) begin
          e_vram = vq.pop_front();
          check("vram_wr_data", vram_wr_data, e_vram);
        end
      end
      if (wr_dropped) drop_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; cpu_reg_sel = '0; cpu_data_in = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    incr32 = 1'b0; render_pal_req = 1'b0; render_pal_addr = '0;
    m_v = '0; m_w = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_en", palette_mem_en, 0);
    check("rst_rw", palette_mem_rw, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_full", fifo_full, 0);
    check("rst_vram_wr", vram_wr, 0);
    check("rst_dropped", wr_dropped, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic palette write.
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'h05); cpu_write(3'd7, 8'h16);
    check("t1_vram_addr", vram_addr, 14'h3F06);
    wait_drain();
    check("t1_en_idle", palette_mem_en, 0);

    // Mirrored and non-mirrored indices.
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'h10); cpu_write(3'd7, 8'h2A);
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'h11); cpu_write(3'd7, 8'h2A);
    wait_drain();

    // Renderer holds the port: queue fills, then overflows.
    render_pal_req = 1'b1; render_pal_addr = 5'h1F;
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'h00);
    for (int i = 1; i <= 4; i++) cpu_write(3'd7, 8'(i));
    check("t3_full", fifo_full, 1);
    check("t3_rd_en", palette_mem_en, 1);
    check("t3_rd_rw", palette_mem_rw, 0);
    check("t3_rd_addr", pal_addr, 5'h1F);
    check("t3_rd_data", palette_data_in, 0);
    drop_base = drop_cnt;
    cpu_write(3'd7, 8'h05, 1);
    @(negedge clk); #1;
    check("t3_dropped", drop_cnt - drop_base, 1);
    check("t3_vram_addr", vram_addr, m_v);
    @(posedge clk); #1;
    render_pal_req = 1'b0;
    wait_drain();
    check("t3_not_full", fifo_full, 0);

    // 32-byte increment wraps out of the palette page.
    incr32 = 1'b1;
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'hF0);
    cpu_write(3'd7, 8'hC5);
    check("t4_vram_addr1", vram_addr, 14'h0010);
    cpu_write(3'd7, 8'h99);
    check("t4_vram_addr2", vram_addr, 14'h0030);
    wait_drain();
    incr32 = 1'b0;

    // Status read resets the write toggle.
    cpu_write(3'd6, 8'h3F); cpu_read(3'd2); cpu_write(3'd6, 8'h21);
    check("t5_addr_hi", vram_addr[13:8], 6'h21);
    cpu_write(3'd6, 8'h45);
    check("t5_addr_full", vram_addr, 14'h2145);
    check("t5_model", vram_addr, m_v);

    // Reset in the middle of a drain flushes the queue.
    render_pal_req = 1'b1; render_pal_addr = 5'h03;
    cpu_write(3'd6, 8'h3F); cpu_write(3'd6, 8'h00);
    cpu_write(3'd7, 8'h11); cpu_write(3'd7, 8'h12); cpu_write(3'd7, 8'h13);
    render_pal_req = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_en", palette_mem_en, 0);
    check("t6_full", fifo_full, 0);
    check("t6_vram_addr", vram_addr, 0);
    sb_q.delete(); vq.delete();
    m_v = '0; m_w = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("t6_no_writes", sb_q.size(), 0);
    check("t6_en_idle", palette_mem_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
